// File: rtl/cpu_pkg.sv
// Shared CPU opcode encodings and small sizing helpers for the pipeline blocks.
package cpu_pkg;

  typedef enum logic [7:0] {
    NOP = 8'd0,
    LW  = 8'd1,
    SW  = 8'd2,
    ADD = 8'd3,
    SUB = 8'd4
  } opcode_e;

  // Countdown width for a load-use window; a 1-cycle latency still needs a 1-bit slot.
  function automatic int cnt_width(input int load_latency);
    return (load_latency <= 2) ? 1 : $clog2(load_latency);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute hazard bus: pipeline side drives selectors and execute info, scoreboard returns stall.
interface hazard_scoreboard_if #(
  parameter int NUM_READ_PORTS = 2,
  parameter int REG_SEL_W      = 4,
  parameter int OPCODE_W       = 8
);
  logic [NUM_READ_PORTS-1:0]           i_decoder_re;
  logic [NUM_READ_PORTS*REG_SEL_W-1:0] i_decoder_rs;
  logic                                i_execute_valid;
  logic [REG_SEL_W-1:0]                i_execute_ws;
  logic [OPCODE_W-1:0]                 i_execute_opcode;
  logic                                i_mem_wait;
  logic                                i_flush;
  logic                                o_stall;
  logic [NUM_READ_PORTS-1:0]           o_stall_port;
  logic                                o_busy;
  logic [15:0]                         o_stall_count;

  modport master (
    output i_decoder_re, i_decoder_rs, i_execute_valid, i_execute_ws,
    output i_execute_opcode, i_mem_wait, i_flush,
    input  o_stall, o_stall_port, o_busy, o_stall_count
  );

  modport slave (
    input  i_decoder_re, i_decoder_rs, i_execute_valid, i_execute_ws,
    input  i_execute_opcode, i_mem_wait, i_flush,
    output o_stall, o_stall_port, o_busy, o_stall_count
  );
endinterface

// File: rtl/scoreboard_entry.sv
// One register's load-use countdown: load wins, else decrement toward 0 when enabled.
// Latency: count updates on the next edge; nonzero flag is combinational from the count.
module scoreboard_entry #(
  parameter int CNT_W = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic             nonzero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec_en && nonzero) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign nonzero = |count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: zero-latency stall from execute-stage LW match or pending countdowns.
// Frozen by i_mem_wait (entries and stall counter hold); stall output stays live throughout.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_READ_PORTS = 2,
  parameter int REG_SEL_W      = 4,
  parameter int LOAD_LATENCY   = 1,
  parameter int OPCODE_W       = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  hazard_scoreboard_if.slave bus
);

  localparam int              NUM_REGS = 2**REG_SEL_W;
  localparam int              CNT_W    = cnt_width(LOAD_LATENCY);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_LATENCY - 1);

  logic                      exec_load;
  logic                      advance;
  logic                      stall;
  logic [NUM_REGS-1:0]       entry_nz;
  logic [NUM_READ_PORTS-1:0] port_hit;
  logic [15:0]               stall_count_q;

  assign exec_load = bus.i_execute_valid
                   & (bus.i_execute_opcode == OPCODE_W'(LW))
                   & ~bus.i_flush;
  assign advance   = ~bus.i_mem_wait;

  // Entry holds the cycles still owed after the load leaves execute; the execute cycle itself
  // is covered by the direct selector compare below.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .load      (advance & exec_load & (bus.i_execute_ws == REG_SEL_W'(r))),
      .load_val  (LOAD_VAL),
      .dec_en    (advance),
      .nonzero   (entry_nz[r])
    );
  end

  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_port
    logic [REG_SEL_W-1:0] rs;
    assign rs          = bus.i_decoder_rs[k*REG_SEL_W +: REG_SEL_W];
    assign port_hit[k] = bus.i_decoder_re[k]
                       & ((exec_load & (rs == bus.i_execute_ws)) | entry_nz[rs]);
  end

  assign stall = |port_hit;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_count_q <= '0;
    end else if (stall && advance && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign bus.o_stall_port  = port_hit;
  assign bus.o_stall       = stall;
  assign bus.o_busy        = |entry_nz;
  assign bus.o_stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: three scoreboards (LOAD_LATENCY 1, 3, 4) share one stimulus stream.
module tb_hazard_scoreboard;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] re;
  logic [7:0] rs;
  logic       vld;
  logic [3:0] ws;
  logic [7:0] opc;
  logic       mw;
  logic       fl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_READ_PORTS(2), .REG_SEL_W(4), .OPCODE_W(8)) if1 ();
  hazard_scoreboard_if #(.NUM_READ_PORTS(2), .REG_SEL_W(4), .OPCODE_W(8)) if3 ();
  hazard_scoreboard_if #(.NUM_READ_PORTS(2), .REG_SEL_W(4), .OPCODE_W(8)) if4 ();

  assign if1.i_decoder_re = re;   assign if3.i_decoder_re = re;   assign if4.i_decoder_re = re;
  assign if1.i_decoder_rs = rs;   assign if3.i_decoder_rs = rs;   assign if4.i_decoder_rs = rs;
  assign if1.i_execute_valid = vld; assign if3.i_execute_valid = vld; assign if4.i_execute_valid = vld;
  assign if1.i_execute_ws = ws;   assign if3.i_execute_ws = ws;   assign if4.i_execute_ws = ws;
  assign if1.i_execute_opcode = opc; assign if3.i_execute_opcode = opc; assign if4.i_execute_opcode = opc;
  assign if1.i_mem_wait = mw;     assign if3.i_mem_wait = mw;     assign if4.i_mem_wait = mw;
  assign if1.i_flush = fl;        assign if3.i_flush = fl;        assign if4.i_flush = fl;

  hazard_scoreboard #(.NUM_READ_PORTS(2), .REG_SEL_W(4), .LOAD_LATENCY(1), .OPCODE_W(8)) d1 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if1.slave));
  hazard_scoreboard #(.NUM_READ_PORTS(2), .REG_SEL_W(4), .LOAD_LATENCY(3), .OPCODE_W(8)) d3 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if3.slave));
  hazard_scoreboard #(.NUM_READ_PORTS(2), .REG_SEL_W(4), .LOAD_LATENCY(4), .OPCODE_W(8)) d4 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(if4.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld = 1'b0; re = 2'b00; rs = 8'h00; ws = 4'h0; opc = NOP; mw = 1'b0; fl = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_busy", 32'(if3.o_busy), 0);
    chk("rst_stall", 32'(if3.o_stall), 0);
    chk("rst_cnt", 32'(if3.o_stall_count), 0);
    rst_n = 1'b1;
    tick();

    // Latency 1: single execute-stage stall, no entry ever set
    do_reset();
    vld = 1'b1; opc = LW; ws = 4'd3; re = 2'b01; rs = 8'h03; #1;
    chk("a_stall_ld", 32'(if1.o_stall), 1);
    chk("a_port", 32'(if1.o_stall_port), 32'b01);
    chk("a_busy0", 32'(if1.o_busy), 0);
    tick(); vld = 1'b0; opc = NOP; #1;
    chk("a_stall_after", 32'(if1.o_stall), 0);
    chk("a_busy1", 32'(if1.o_busy), 0);
    chk("a_cnt", 32'(if1.o_stall_count), 1);

    // Latency 3: three stall cycles on read port 1
    do_reset();
    vld = 1'b1; opc = LW; ws = 4'd5; re = 2'b10; rs = 8'h50; #1;
    chk("b_s0", 32'(if3.o_stall), 1);
    chk("b_port", 32'(if3.o_stall_port), 32'b10);
    tick(); vld = 1'b0; opc = NOP; #1;
    chk("b_s1", 32'(if3.o_stall), 1);
    chk("b_busy", 32'(if3.o_busy), 1);
    tick(); #1;
    chk("b_s2", 32'(if3.o_stall), 1);
    tick(); #1;
    chk("b_s3", 32'(if3.o_stall), 0);
    chk("b_busy_end", 32'(if3.o_busy), 0);
    chk("b_cnt", 32'(if3.o_stall_count), 3);

    // Latency 3 with a 4-cycle memory freeze after the entry loads
    do_reset();
    vld = 1'b1; opc = LW; ws = 4'd5; re = 2'b10; rs = 8'h50; #1;
    chk("c_s0", 32'(if3.o_stall), 1);
    tick(); vld = 1'b0; opc = NOP; mw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("c_wait_stall", 32'(if3.o_stall), 1);
      tick();
    end
    chk("c_cnt_wait", 32'(if3.o_stall_count), 1);
    mw = 1'b0; #1;
    chk("c_s5", 32'(if3.o_stall), 1);
    tick(); #1;
    chk("c_s6", 32'(if3.o_stall), 1);
    tick(); #1;
    chk("c_s7", 32'(if3.o_stall), 0);
    chk("c_cnt", 32'(if3.o_stall_count), 3);

    // A load seen while memory is busy must not create an entry
    do_reset();
    vld = 1'b1; opc = LW; ws = 4'd6; mw = 1'b1; #1;
    chk("e_s0", 32'(if3.o_stall), 0);
    tick(); idle(); re = 2'b01; rs = 8'h06; #1;
    chk("e_stall", 32'(if3.o_stall), 0);
    chk("e_busy", 32'(if3.o_busy), 0);

    // Flushed load and a non-load writer never stall
    do_reset();
    vld = 1'b1; opc = LW; ws = 4'd7; fl = 1'b1; re = 2'b01; rs = 8'h07; #1;
    chk("d_flush_stall", 32'(if3.o_stall), 0);
    tick(); vld = 1'b0; fl = 1'b0; opc = NOP; #1;
    chk("d_busy", 32'(if3.o_busy), 0);
    chk("d_stall", 32'(if3.o_stall), 0);
    tick(); vld = 1'b1; opc = ADD; ws = 4'd7; #1;
    chk("d_add", 32'(if3.o_stall), 0);

    // Latency 4: reset mid-countdown drops the hazard asynchronously
    do_reset();
    vld = 1'b1; opc = LW; ws = 4'd2; re = 2'b01; rs = 8'h02; #1;
    chk("f_s0", 32'(if4.o_stall), 1);
    tick(); vld = 1'b0; opc = NOP; #1;
    chk("f_busy", 32'(if4.o_busy), 1);
    chk("f_cnt", 32'(if4.o_stall_count), 1);
    chk("f_s1", 32'(if4.o_stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("f_rst_busy", 32'(if4.o_busy), 0);
    chk("f_rst_cnt", 32'(if4.o_stall_count), 0);
    chk("f_rst_stall", 32'(if4.o_stall), 0);
    tick(); rst_n = 1'b1; #1;
    chk("f_post", 32'(if4.o_stall), 0);
    tick();
    chk("f_post2", 32'(if4.o_stall), 0);

    // Stall counter saturation
    do_reset();
    vld = 1'b1; opc = LW; ws = 4'd1; re = 2'b01; rs = 8'h01;
    repeat (65534) tick();
    chk("g_cnt_pre", 32'(if1.o_stall_count), 65534);
    tick();
    chk("g_cnt_sat", 32'(if1.o_stall_count), 32'hFFFF);
    repeat (4465) tick();
    chk("g_cnt_hold", 32'(if1.o_stall_count), 32'hFFFF);
    chk("g_stall", 32'(if1.o_stall), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
